// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mdu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] MDU_MULTU = 3'b000;
  localparam logic [OP_W-1:0] MDU_MULT  = 3'b001;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'b010;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'b011;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op[2:1] == 2'b00);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider on operand magnitudes; one quotient bit per step.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude
  always_comb begin
    mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  always_comb begin
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (load) begin
      quot_q <= mag_a;
      rem_q  <= '0;
      dvs_q  <= mag_b;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q  <= diff[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q  <= rem_sh[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO, MTHI/MTLO writes and flush cancel.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             done_d, busy_d;
  logic             accept;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             q_neg, r_neg;

  assign accept = start && (state == S_IDLE) && !cancel;

  // Operands captured at acceptance feed both the multiplier and the sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= op[0];
    end
  end

  // Low 2W bits of the product of sign/zero-extended operands give the exact result
  always_comb begin
    ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
  end

  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && op_is_div(op)),
    .step      (state == S_DIV),
    .is_signed (op[0]),
    .a         (a),
    .b         (b),
    .quot      (quot),
    .rem       (rem)
  );

  // Most-negative / -1 needs no special case: negating the magnitude wraps back to itself
  always_comb begin
    q_neg   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg   = sgn_q && a_q[WIDTH-1];
    quo_fix = q_neg ? (~quot + WIDTH'(1)) : quot;
    rem_fix = r_neg ? (~rem + WIDTH'(1)) : rem;
    if (b_q == '0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && op_is_mul(op))      state_d = S_MUL;
          else if (accept && op_is_div(op)) state_d = S_DIV;
        end
        S_MUL:   if (cnt == CNT_W'(MUL_LAT)) state_d = S_IDLE;
        S_DIV:   if (cnt == CNT_W'(WIDTH))   state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hi_d   = hi;
    lo_d   = lo;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    cnt_d  = cnt;
    if (cancel) begin
      cnt_d = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == MDU_MTHI) hi_d = a;
            if (op == MDU_MTLO) lo_d = a;
            if (op_is_mul(op) || op_is_div(op)) cnt_d = CNT_W'(1);
          end
        end
        S_MUL: begin
          if (cnt == CNT_W'(MUL_LAT)) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (cnt == CNT_W'(WIDTH)) cnt_d = '0;
          else                      cnt_d = cnt + CNT_W'(1);
        end
        S_FIX: begin
          hi_d   = rem_fix;
          lo_d   = quo_fix;
          done_d = 1'b1;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      hi   <= hi_d;
      lo   <= lo_d;
      done <= done_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu at WIDTH=32, MUL_LAT=5.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  mdu #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  // Steps until done, recording whether busy stayed high beforehand; bounded at 200 cycles
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
  endtask

  int n;
  bit bok;
  bit seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b110; a = '0; b = '0; cancel = 1'b0;
    step(); step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();

    // MULT -2 * 3
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(n, bok);
    chk("mult_lat", 64'(n), 64'd5);
    chk("mult_busy_held", 64'(bok), 64'd1);
    chk("mult_busy_fall", 64'(busy), 64'd0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    // Back-to-back: request MULTU in the done cycle
    start = 1'b1; op = MDU_MULTU; a = 32'hFFFF_FFFE; b = 32'd3;
    step();
    start = 1'b0;
    chk("b2b_done_pulse", 64'(done), 64'd0);
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_done(n, bok);
    chk("multu_lat", 64'(n), 64'd5);
    chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    step();

    // DIV -7 / 2
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bok);
    chk("div_lat", 64'(n), 64'd33);
    chk("div_busy_held", 64'(bok), 64'd1);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    step();
    chk("div_done_once", 64'(done), 64'd0);

    // DIVU 100 / 7
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_done(n, bok);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    // Divide by zero
    issue(MDU_DIV, 32'h0000_1234, 32'd0);
    wait_done(n, bok);
    chk("div0_lat", 64'(n), 64'd33);
    chk("div0_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

    // Signed overflow
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bok);
    chk("ovf_hilo", {hi, lo}, {32'h0, 32'h8000_0000});
    step();

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = MDU_MTHI; a = 32'h0000_DEAD;
    step();
    chk("mthi_hi", 64'(hi), 64'h0000_DEAD);
    chk("mthi_busy", 64'(busy), 64'd0);
    op = MDU_MTLO; a = 32'h0000_BEEF;
    step();
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, 64'h0000_DEAD_0000_BEEF);
    chk("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

    // Cancel together with start in IDLE: nothing accepted
    start = 1'b1; op = MDU_MTHI; a = 32'h5555_5555; cancel = 1'b1;
    step();
    op = MDU_DIV;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_idle_hi", 64'(hi), 64'h0000_DEAD);
    chk("cancel_idle_busy", 64'(busy), 64'd0);

    // Prime hi/lo = 1/2, cancel DIV at cycle 10
    start = 1'b1; op = MDU_MTHI; a = 32'd1;
    step();
    op = MDU_MTLO; a = 32'd2;
    step();
    start = 1'b0;
    issue(MDU_DIV, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hilo", {hi, lo}, {32'd1, 32'd2});
    seen = (done === 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("cancel_no_done", 64'(seen), 64'd0);

    // Reset mid-MUL clears everything immediately
    issue(MDU_MULT, 32'd7, 32'd9);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // MULTU while DIV busy is ignored
    issue(MDU_DIVU, 32'd100, 32'd7);
    start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
    for (int i = 0; i < 5; i++) step();
    start = 1'b0;
    wait_done(n, bok);
    chk("busy_ign_lat", 64'(n + 5), 64'd33);
    chk("busy_ign_hilo", {hi, lo}, {32'd2, 32'd14});
    step();
    chk("busy_ign_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
